// File: rtl/wishbone_master_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wishbone_master_pkg
//  Description : Shared state encoding and default sizing for the Wishbone
//                pipelined-mode initiator and its timeout counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package wishbone_master_pkg;

    // Default bus sizing and timeout budget
    localparam int unsigned c_DEF_ADDR_WIDTH     = 2;
    localparam int unsigned c_DEF_DATA_WIDTH     = 32;
    localparam int unsigned c_DEF_TIMEOUT_CYCLES = 16;

    // Initiator state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } wb_state_e;

endpackage
`default_nettype wire

// File: rtl/wb_timeout_counter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_timeout_counter
//  Description : Cycle counter guarding one Wishbone bus cycle. Cleared when a
//                command is accepted, counts while enabled, and flags expiry
//                once it has reached TIMEOUT_CYCLES-1.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int unsigned        c_CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0] count_q;
    logic [c_CNT_W-1:0] count_d;

    // Expiry is decoded from the registered count so it is glitch-free
    assign o_expired = (count_q == c_LAST);

    // Next count: clear wins, then saturating increment
    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_enable && !o_expired) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wishbone_master.sv
`default_nettype none
// ============================================================================
//  Module      : wishbone_master
//  Description : Wishbone B4 pipelined-mode initiator. Turns one command at a
//                time into a single read or write bus cycle, honours STALL,
//                collects ACK/ERR/read data and abandons the cycle after a
//                timeout. Produces exactly one response pulse per command.
//  Revision    : 1.0 - initial release
// ============================================================================
module wishbone_master
    import wishbone_master_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = c_DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = c_DEF_DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = c_DEF_TIMEOUT_CYCLES
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    // command side
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_cmd_we,
    input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [DATA_WIDTH-1:0] i_cmd_data,
    // response side
    output logic                  o_rsp_valid,
    output logic [DATA_WIDTH-1:0] o_rsp_data,
    output logic                  o_rsp_err,
    output logic                  o_rsp_timeout,
    // wishbone side
    output logic                  o_wb_cyc,
    output logic                  o_wb_stb,
    output logic                  o_wb_we,
    output logic [ADDR_WIDTH-1:0] o_wb_addr,
    output logic [DATA_WIDTH-1:0] o_wb_odata,
    input  logic                  i_wb_ack,
    input  logic                  i_wb_stall,
    input  logic                  i_wb_err,
    input  logic [DATA_WIDTH-1:0] i_wb_idata
);

    wb_state_e             state_q, state_d;
    logic                  cyc_q, cyc_d;
    logic                  stb_q, stb_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] odata_q, odata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_timeout_q, rsp_timeout_d;

    logic w_cnt_clear;
    logic w_cnt_enable;
    logic w_expired;
    logic w_done;

    // Any slave termination ends the cycle; ERR is resolved below
    assign w_done = i_wb_ack | i_wb_err;

    wb_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_clear   (w_cnt_clear),
        .i_enable  (w_cnt_enable),
        .o_expired (w_expired)
    );

    // Next-state, bus and response decode
    always_comb begin
        state_d       = state_q;
        cyc_d         = cyc_q;
        stb_d         = stb_q;
        we_d          = we_q;
        addr_d        = addr_q;
        odata_d       = odata_q;
        rsp_valid_d   = 1'b0;
        rsp_data_d    = '0;
        rsp_err_d     = 1'b0;
        rsp_timeout_d = 1'b0;
        w_cnt_clear   = 1'b0;
        w_cnt_enable  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Slave handshakes here are stale and deliberately ignored
                if (i_cmd_valid) begin
                    we_d        = i_cmd_we;
                    addr_d      = i_cmd_addr;
                    odata_d     = i_cmd_data;
                    cyc_d       = 1'b1;
                    stb_d       = 1'b1;
                    w_cnt_clear = 1'b1;
                    state_d     = ST_REQ;
                end
            end

            ST_REQ, ST_WAIT: begin
                w_cnt_enable = 1'b1;
                if (w_done) begin
                    // A real termination beats a timeout in the expiry cycle
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    if (i_wb_err) begin
                        rsp_err_d = 1'b1;
                    end else if (!we_q) begin
                        rsp_data_d = i_wb_idata;
                    end
                end else if (w_expired) begin
                    cyc_d         = 1'b0;
                    stb_d         = 1'b0;
                    state_d       = ST_IDLE;
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else if ((state_q == ST_REQ) && !i_wb_stall) begin
                    // Request taken by the slave; keep CYC, drop STB
                    stb_d   = 1'b0;
                    state_d = ST_WAIT;
                end
            end

            default: begin
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, bus and response registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q       <= ST_IDLE;
            cyc_q         <= 1'b0;
            stb_q         <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            odata_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cyc_q         <= cyc_d;
            stb_q         <= stb_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            odata_q       <= odata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign o_cmd_ready   = (state_q == ST_IDLE);
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_data    = rsp_data_q;
    assign o_rsp_err     = rsp_err_q;
    assign o_rsp_timeout = rsp_timeout_q;
    assign o_wb_cyc      = cyc_q;
    assign o_wb_stb      = stb_q;
    assign o_wb_we       = we_q;
    assign o_wb_addr     = addr_q;
    assign o_wb_odata    = odata_q;

endmodule
`default_nettype wire

// File: tb/tb_wishbone_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wishbone_master
//  Description : Self-checking bench for wishbone_master. Each transaction is
//                planned up front (stall length, ack delay, outcome); the plan
//                yields both the slave stimulus and the expected per-cycle
//                outputs, which are compared against the DUT every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wishbone_master;

    localparam int AW   = 2;
    localparam int DW   = 32;
    localparam int T    = 16;
    localparam int MAXC = 3000;

    localparam int K_ACK  = 0;
    localparam int K_ERR  = 1;
    localparam int K_BOTH = 2;
    localparam int K_NONE = 3;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_cmd_valid = 1'b0;
    logic          i_cmd_we    = 1'b0;
    logic [AW-1:0] i_cmd_addr  = '0;
    logic [DW-1:0] i_cmd_data  = '0;
    logic          i_wb_ack    = 1'b0;
    logic          i_wb_stall  = 1'b0;
    logic          i_wb_err    = 1'b0;
    logic [DW-1:0] i_wb_idata  = '0;

    logic          o_cmd_ready;
    logic          o_rsp_valid;
    logic [DW-1:0] o_rsp_data;
    logic          o_rsp_err;
    logic          o_rsp_timeout;
    logic          o_wb_cyc;
    logic          o_wb_stb;
    logic          o_wb_we;
    logic [AW-1:0] o_wb_addr;
    logic [DW-1:0] o_wb_odata;

    wishbone_master #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_cmd_valid   (i_cmd_valid),
        .o_cmd_ready   (o_cmd_ready),
        .i_cmd_we      (i_cmd_we),
        .i_cmd_addr    (i_cmd_addr),
        .i_cmd_data    (i_cmd_data),
        .o_rsp_valid   (o_rsp_valid),
        .o_rsp_data    (o_rsp_data),
        .o_rsp_err     (o_rsp_err),
        .o_rsp_timeout (o_rsp_timeout),
        .o_wb_cyc      (o_wb_cyc),
        .o_wb_stb      (o_wb_stb),
        .o_wb_we       (o_wb_we),
        .o_wb_addr     (o_wb_addr),
        .o_wb_odata    (o_wb_odata),
        .i_wb_ack      (i_wb_ack),
        .i_wb_stall    (i_wb_stall),
        .i_wb_err      (i_wb_err),
        .i_wb_idata    (i_wb_idata)
    );

    always #5 clk = ~clk;

    // cycle n starts at posedge n; inputs driven in cycle n are sampled at posedge n+1
    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // stimulus plan
    logic          d_valid [MAXC];
    logic          d_we    [MAXC];
    logic [AW-1:0] d_addr  [MAXC];
    logic [DW-1:0] d_data  [MAXC];
    logic          d_ack   [MAXC];
    logic          d_err   [MAXC];
    logic          d_stall [MAXC];
    logic [DW-1:0] d_idata [MAXC];

    // expected outputs per cycle
    logic          e_cyc   [MAXC];
    logic          e_stb   [MAXC];
    logic          e_we    [MAXC];
    logic [AW-1:0] e_addr  [MAXC];
    logic [DW-1:0] e_odata [MAXC];
    logic          e_ready [MAXC];
    logic          e_rv    [MAXC];
    logic [DW-1:0] e_rdata [MAXC];
    logic          e_err   [MAXC];
    logic          e_to    [MAXC];

    int pa [4];
    int e0 = MAXC - 20;
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", nm, cyc_n, act, exp);
        end
    endtask

    // Main: build plan, reset, then directed async-reset check and summary
    initial begin
        int a, s, d, kind, len, c, gap, r, k;
        logic          w, has_rsp, is_ack, is_err;
        logic [AW-1:0] ad;
        logic [DW-1:0] wd, rd;

        for (int n = 0; n < MAXC; n++) begin
            d_valid[n] = 1'b0;
            d_we[n]    = 1'b0;
            d_addr[n]  = '0;
            d_data[n]  = '0;
            d_ack[n]   = ($urandom_range(0, 3) == 0);
            d_err[n]   = ($urandom_range(0, 5) == 0);
            d_stall[n] = 1'($urandom_range(0, 1));
            d_idata[n] = $urandom;
            e_cyc[n]   = 1'b0;
            e_stb[n]   = 1'b0;
            e_we[n]    = 1'b0;
            e_addr[n]  = '0;
            e_odata[n] = '0;
            e_ready[n] = 1'b1;
            e_rv[n]    = 1'b0;
            e_rdata[n] = '0;
            e_err[n]   = 1'b0;
            e_to[n]    = 1'b0;
        end

        a = 10;
        for (int t = 0; t < 400 && a < MAXC - 100; t++) begin
            w   = 1'($urandom_range(0, 1));
            ad  = AW'($urandom_range(0, 3));
            wd  = $urandom;
            rd  = $urandom;
            s   = $urandom_range(0, 10);
            d   = $urandom_range(0, 8);
            gap = $urandom_range(0, 2);
            k   = $urandom_range(0, 9);
            kind = (k < 6) ? K_ACK : (k == 6) ? K_ERR : (k == 7) ? K_BOTH : (k == 8) ? K_NONE : K_ACK;
            case (t)
                0: begin w = 1'b1; ad = 2'd1; wd = 32'h0000_0001; s = 0; d = 0; kind = K_ACK; gap = 0; end
                1: begin w = 1'b0; ad = 2'd2; rd = 32'hDEAD_BEEF; s = 3; d = 2; kind = K_ACK; gap = 0; end
                2: begin w = 1'b0; s = 0; d = 1; kind = K_BOTH; gap = 1; end
                3: begin kind = K_NONE; gap = 3; end
                4: begin w = 1'b0; s = 7; d = 8; kind = K_ACK; end
                5: begin w = 1'b0; s = 8; d = 8; kind = K_ACK; end
                default: ;
            endcase
            if (t < 4) pa[t] = a;

            c       = s + 1 + d;
            is_ack  = (kind == K_ACK) || (kind == K_BOTH);
            is_err  = (kind == K_ERR) || (kind == K_BOTH);
            has_rsp = (kind != K_NONE) && (c <= T);
            len     = has_rsp ? c : T;

            d_valid[a] = 1'b1;
            d_we[a]    = w;
            d_addr[a]  = ad;
            d_data[a]  = wd;
            for (int i = 1; i <= len; i++) begin
                d_valid[a+i] = 1'($urandom_range(0, 1));
                d_we[a+i]    = 1'($urandom_range(0, 1));
                d_addr[a+i]  = AW'($urandom_range(0, 3));
                d_data[a+i]  = $urandom;
                d_stall[a+i] = (i <= s);
                d_ack[a+i]   = has_rsp && is_ack && (i == c);
                d_err[a+i]   = has_rsp && is_err && (i == c);
                d_idata[a+i] = (i == c) ? rd : $urandom;
                e_cyc[a+i]   = 1'b1;
                e_stb[a+i]   = (i <= s + 1);
                e_ready[a+i] = 1'b0;
            end
            for (int n = a + 1; n < MAXC; n++) begin
                e_we[n]    = w;
                e_addr[n]  = ad;
                e_odata[n] = wd;
            end
            r = a + len + 1;
            e_rv[r]    = 1'b1;
            e_err[r]   = has_rsp && is_err;
            e_to[r]    = !has_rsp;
            e_rdata[r] = (has_rsp && !is_err && !w) ? rd : '0;
            if (!has_rsp) d_ack[r] = 1'b1;
            if (t == 3) d_ack[r+1] = 1'b1;
            a = r + gap;
        end

        e0 = a + 3;
        for (int n = a + 1; n < MAXC; n++) begin
            d_valid[n] = 1'b0;
            d_ack[n]   = 1'b0;
            d_err[n]   = 1'b0;
            d_stall[n] = 1'b0;
        end
        d_valid[e0] = 1'b1;
        d_we[e0]    = 1'b0;
        d_addr[e0]  = 2'd3;
        d_data[e0]  = 32'h1234_5678;

        while (cyc_n < 3) @(negedge clk);
        chk("rst_cyc",   32'(o_wb_cyc), 0);
        chk("rst_stb",   32'(o_wb_stb), 0);
        chk("rst_ready", 32'(o_cmd_ready), 1);
        chk("rst_rv",    32'(o_rsp_valid), 0);
        chk("rst_addr",  32'(o_wb_addr), 0);
        chk("rst_odata", o_wb_odata, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed: reset asserted between edges while the cycle sits in WAIT
        while (cyc_n < e0 + 2) @(negedge clk);
        chk("dir_wait_cyc", 32'(o_wb_cyc), 1);
        chk("dir_wait_stb", 32'(o_wb_stb), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("dir_async_cyc",   32'(o_wb_cyc), 0);
        chk("dir_async_stb",   32'(o_wb_stb), 0);
        chk("dir_async_rv",    32'(o_rsp_valid), 0);
        chk("dir_async_ready", 32'(o_cmd_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("dir_post_rv",    32'(o_rsp_valid), 0);
            chk("dir_post_ready", 32'(o_cmd_ready), 1);
            chk("dir_post_cyc",   32'(o_wb_cyc), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Driver: apply the planned inputs for the current cycle
    initial begin
        forever begin
            @(negedge clk);
            if (cyc_n < MAXC) begin
                i_cmd_valid = d_valid[cyc_n];
                i_cmd_we    = d_we[cyc_n];
                i_cmd_addr  = d_addr[cyc_n];
                i_cmd_data  = d_data[cyc_n];
                i_wb_ack    = d_ack[cyc_n];
                i_wb_err    = d_err[cyc_n];
                i_wb_stall  = d_stall[cyc_n];
                i_wb_idata  = d_idata[cyc_n];
            end
        end
    end

    // Compare: DUT outputs against the planned expectations every cycle
    initial begin
        int n;
        int to_len;
        to_len = 0;
        forever begin
            @(negedge clk);
            n = cyc_n;
            if (n >= 5 && n <= e0) begin
                chk("cyc",     32'(o_wb_cyc),      32'(e_cyc[n]));
                chk("stb",     32'(o_wb_stb),      32'(e_stb[n]));
                chk("we",      32'(o_wb_we),       32'(e_we[n]));
                chk("addr",    32'(o_wb_addr),     32'(e_addr[n]));
                chk("odata",   o_wb_odata,         e_odata[n]);
                chk("ready",   32'(o_cmd_ready),   32'(e_ready[n]));
                chk("rsp_v",   32'(o_rsp_valid),   32'(e_rv[n]));
                chk("rsp_d",   o_rsp_data,         e_rdata[n]);
                chk("rsp_err", 32'(o_rsp_err),     32'(e_err[n]));
                chk("rsp_to",  32'(o_rsp_timeout), 32'(e_to[n]));

                if (n == pa[0] + 1) begin
                    chk("pin_wr_stb",  32'(o_wb_stb), 1);
                    chk("pin_wr_addr", 32'(o_wb_addr), 1);
                    chk("pin_wr_data", o_wb_odata, 32'h0000_0001);
                end
                if (n == pa[0] + 2) begin
                    chk("pin_wr_rsp",   32'(o_rsp_valid), 1);
                    chk("pin_wr_ready", 32'(o_cmd_ready), 1);
                    chk("pin_wr_stb0",  32'(o_wb_stb), 0);
                end
                if (n >= pa[1] + 1 && n <= pa[1] + 4) begin
                    chk("pin_rd_stb",  32'(o_wb_stb), 1);
                    chk("pin_rd_addr", 32'(o_wb_addr), 2);
                end
                if (n == pa[1] + 5) chk("pin_rd_stb0", 32'(o_wb_stb), 0);
                if (n == pa[1] + 7) begin
                    chk("pin_rd_rv",   32'(o_rsp_valid), 1);
                    chk("pin_rd_data", o_rsp_data, 32'hDEAD_BEEF);
                end
                if (n == pa[2] + 3) begin
                    chk("pin_err_flag", 32'(o_rsp_err), 1);
                    chk("pin_err_data", o_rsp_data, 0);
                    chk("pin_err_cyc",  32'(o_wb_cyc), 0);
                end
                if (n > pa[3] && n <= pa[3] + 17 && o_wb_cyc) to_len++;
                if (n == pa[3] + 17) begin
                    chk("pin_to_flag",    32'(o_rsp_timeout), 1);
                    chk("pin_to_cyc_len", 32'(to_len), 16);
                end
                if (n == pa[3] + 18 || n == pa[3] + 19) chk("pin_stale_ack", 32'(o_rsp_valid), 0);
            end
        end
    end

    // Bound the run
    initial begin
        #((MAXC + 200) * 10);
        $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc_n);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
